// File: rtl/si5340_i2c_writer.sv
// Single-register I2C write initiator for the SI5340A0/A1 clock generators.
// Optional responder clock stretching with timeout is enabled by defining I2C_CLOCK_STRETCH_EN.
`timescale 1ns/1ps
module si5340_i2c_writer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int I2C_HZ      = 100_000,
  parameter int STRETCH_MAX = 65535
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic       rsp_timeout,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  localparam int QTR = CLK_HZ / (4 * I2C_HZ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BITS, S_ACK, S_STOP, S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    data_q, data_d;
  logic          nack_q, nack_d;
  logic          scl_oe_q, scl_oe_d;
  logic          sda_oe_q, sda_oe_d;
  logic [1:0]    sda_s_q;
  logic [7:0]    cur_byte;
  logic          tx_bit;
  logic          qend, adv, stall, tmo_hit;

`ifdef I2C_CLOCK_STRETCH_EN
  localparam int SW = $clog2(STRETCH_MAX + 2);
  logic [1:0]    scl_s_q;
  logic [1:0]    rel_q, rel_d;
  logic [SW-1:0] str_q, str_d;
  logic          tmo_q, tmo_d;
  logic          win;

  // rel_q waits out output register + synchroniser latency after SCL is
  // released, so our own low level is never mistaken for a stretch.
  always_comb begin
    win     = ((state_q == S_BITS || state_q == S_ACK) && qtr_q[1]) ||
              (state_q == S_STOP && (qtr_q == 2'd1 || qtr_q == 2'd2));
    rel_d   = scl_oe_q ? 2'd0 : ((rel_q == 2'd3) ? 2'd3 : rel_q + 2'd1);
    stall   = win && !scl_oe_q && (rel_q == 2'd3) && !scl_s_q[1];
    str_d   = stall ? str_q + SW'(1) : '0;
    tmo_hit = stall && (str_q >= SW'(STRETCH_MAX));
    tmo_d   = (state_q == S_IDLE && cmd_valid) ? 1'b0 : (tmo_q | tmo_hit);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_s_q <= 2'b11;
      rel_q   <= 2'd0;
      str_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      scl_s_q <= {scl_s_q[0], scl_in};
      rel_q   <= rel_d;
      str_q   <= str_d;
      tmo_q   <= tmo_d;
    end
  end

  assign rsp_timeout = tmo_q;
`else
  logic scl_unused;
  assign scl_unused  = scl_in;
  assign stall       = 1'b0;
  assign tmo_hit     = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = {dev_q, 1'b0};
      2'd1:    cur_byte = reg_q;
      default: cur_byte = data_q;
    endcase
    tx_bit = cur_byte[3'd7 - bit_q];
    qend   = (qcnt_q == QLAST);
    adv    = qend && !stall;
  end

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    data_d   = data_q;
    nack_d   = nack_q;
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;

    if (state_q != S_IDLE && state_q != S_RESP && !stall) begin
      qcnt_d = qend ? '0 : qcnt_q + QW'(1);
      if (qend) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          data_d  = cmd_data;
          nack_d  = 1'b0;
          qcnt_d  = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        scl_oe_d = (qtr_q == 2'd3);
        sda_oe_d = (qtr_q != 2'd0);
        if (adv && qtr_q == 2'd3) state_d = S_BITS;
      end
      S_BITS: begin
        scl_oe_d = !qtr_q[1];
        sda_oe_d = !tx_bit;
        if (adv && qtr_q == 2'd3) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ACK;
        end
      end
      S_ACK: begin
        scl_oe_d = !qtr_q[1];
        if (adv && qtr_q == 2'd2 && sda_s_q[1]) nack_d = 1'b1;
        if (adv && qtr_q == 2'd3) begin
          if (nack_q || byte_q == 2'd2) begin
            state_d = S_STOP;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_BITS;
          end
        end
      end
      S_STOP: begin
        scl_oe_d = (qtr_q == 2'd0);
        sda_oe_d = (qtr_q != 2'd3);
        if (adv && qtr_q == 2'd3) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stretch timeout abandons the transfer without a STOP.
    if (tmo_hit) begin
      state_d  = S_RESP;
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      qcnt_q   <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      data_q   <= 8'd0;
      nack_q   <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      sda_s_q  <= 2'b11;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      nack_q   <= nack_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      sda_s_q  <= {sda_s_q[0], sda_in};
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_nack  = nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
endmodule

// File: tb/tb_si5340_i2c_writer.sv
// Directed bench for si5340_i2c_writer: acts as the I2C responder, decodes the bus
// and checks handshake timing, bytes, ACK/NACK status and mid-transfer reset.
`timescale 1ns/1ps
module tb_si5340_i2c_writer;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, rsp_valid, rsp_nack, rsp_timeout, scl_oe, sda_oe;
  logic       scl_line, sda_line;
  logic       ack_pull = 1'b0, scl_pull = 1'b0;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, rsp_cyc = 0, accs = 0, rsps = 0;
  int nb = 0, bitc = 0, stops = 0;
  logic [8:0] sreg = '0;
  logic [7:0] bytes [3];
  logic [2:0] ack_en = 3'b111;
  logic scl_p = 1'b1, sda_p = 1'b1, oe_p = 1'b0, scl_l, sda_l;
  int  str_len = 0, str_hold = 0, str_byte = 0;
  bit  str_en = 1'b0;

  assign scl_line = ~scl_oe & ~scl_pull;
  assign sda_line = ~sda_oe & ~ack_pull;

  always #5 CLK = ~CLK;

  si5340_i2c_writer dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_line), .sda_in(sda_line)
  );

  // Handshake log: cycle index of each accept and response.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin acc_cyc <= cyc; accs <= accs + 1; end
    if (rsp_valid) begin rsp_cyc <= cyc; rsps <= rsps + 1; end
  end

  // Responder model and bus decoder.
  always @(negedge CLK) begin
    if (str_en && oe_p && !scl_oe && nb == str_byte && bitc == 8) begin
      scl_pull = 1'b1; str_hold = str_len; str_en = 1'b0;
    end else if (scl_pull) begin
      str_hold--;
      if (str_hold <= 0) scl_pull = 1'b0;
    end
    oe_p  = scl_oe;
    scl_l = ~scl_oe & ~scl_pull;
    sda_l = ~sda_oe & ~ack_pull;
    if (scl_p && scl_l && sda_p && !sda_l) begin nb = 0; bitc = 0; end
    if (scl_p && scl_l && !sda_p && sda_l) stops++;
    if (!scl_p && scl_l) begin
      sreg = {sreg[7:0], sda_l};
      bitc++;
      if (bitc == 9) begin
        if (nb < 3) bytes[nb] = sreg[8:1];
        nb++; bitc = 0;
      end
    end
    if (scl_p && !scl_l) ack_pull = (bitc == 8) && (nb < 3) && ack_en[nb];
    scl_p = scl_l;
    sda_p = ~sda_oe & ~ack_pull;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [6:0] d, input logic [7:0] r, input logic [7:0] v);
    int a0 = accs;
    int k = 0;
    cmd_dev = d; cmd_reg = r; cmd_data = v; cmd_valid = 1'b1;
    @(negedge CLK);
    while (accs == a0 && k < 10) begin @(negedge CLK); k++; end
    cmd_valid = 1'b0;
    chk("accept", accs - a0, 1);
  endtask

  task automatic wait_rsp(input int n0, input int lim);
    int k = 0;
    while (rsps == n0 && k < lim) begin @(negedge CLK); k++; end
    chk("rsp_arrives", (rsps != n0), 1);
  endtask

  initial begin
    int r0, a0, rsp1, bad, k, lat;
    repeat (3) @(negedge CLK);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_nack", rsp_nack, 0);
    chk("rst_timeout", rsp_timeout, 0);
    RST_N = 1'b1;

    // Idle with no command: lines released, ready held.
    bad = 0;
    repeat (1000) begin
      @(negedge CLK);
      if (scl_oe || sda_oe || !cmd_ready || rsp_valid) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Full ACKed write: 116 quarters of 125 cycles, response on the following cycle index.
    ack_en = 3'b111; r0 = rsps; k = stops;
    send(7'h74, 8'h01, 8'h0B);
    wait_rsp(r0, 20000);
    chk("wr_latency", rsp_cyc - acc_cyc, 14501);
    chk("wr_nack", rsp_nack, 0);
    chk("wr_timeout", rsp_timeout, 0);
    chk("wr_nbytes", nb, 3);
    chk("wr_byte0", bytes[0], 8'hE8);
    chk("wr_byte1", bytes[1], 8'h01);
    chk("wr_byte2", bytes[2], 8'h0B);
    chk("wr_stop", stops - k, 1);
    chk("wr_pulse_1cyc", rsp_valid, 0);
    chk("wr_ready_after", cmd_ready, 1);

    // Address NACK: START + 8 bits + ACK + STOP = 44 quarters.
    ack_en = 3'b110; r0 = rsps; k = stops;
    send(7'h74, 8'h01, 8'h0B);
    wait_rsp(r0, 10000);
    chk("nk_latency", rsp_cyc - acc_cyc, 5501);
    chk("nk_nack", rsp_nack, 1);
    chk("nk_nbytes", nb, 1);
    chk("nk_byte0", bytes[0], 8'hE8);
    chk("nk_stop", stops - k, 1);

    // cmd_valid held: next accept exactly one cycle after rsp_valid.
    ack_en = 3'b110; r0 = rsps; a0 = accs;
    cmd_dev = 7'h75; cmd_reg = 8'h22; cmd_data = 8'h33; cmd_valid = 1'b1;
    wait_rsp(r0, 10000);
    rsp1 = rsp_cyc;
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("b2b_accepts", accs - a0, 2);
    chk("b2b_gap", acc_cyc - rsp1, 1);
    chk("b2b_busy", cmd_ready, 0);
    wait_rsp(r0 + 1, 10000);
    chk("b2b_no_extra", accs - a0, 2);
    chk("b2b_byte0", bytes[0], 8'hEA);

    // Reset during bit 5 of the register byte.
    ack_en = 3'b111; r0 = rsps;
    send(7'h76, 8'hA5, 8'h5A);
    k = 0;
    while (!(nb == 1 && bitc == 5) && k < 10000) begin @(negedge CLK); k++; end
    chk("mid_reached", (nb == 1 && bitc == 5), 1);
    RST_N = 1'b0;
    #1;
    chk("mid_scl_rel", scl_oe, 0);
    chk("mid_sda_rel", sda_oe, 0);
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2000) @(negedge CLK);
    chk("mid_no_rsp", rsps - r0, 0);
    chk("mid_ready", cmd_ready, 1);
    send(7'h77, 8'h3C, 8'hC3);
    wait_rsp(r0, 20000);
    chk("post_latency", rsp_cyc - acc_cyc, 14501);
    chk("post_nack", rsp_nack, 0);
    chk("post_byte0", bytes[0], 8'hEE);
    chk("post_byte1", bytes[1], 8'h3C);
    chk("post_byte2", bytes[2], 8'hC3);

`ifdef I2C_CLOCK_STRETCH_EN
    // Responder stretches SCL on the register-byte ACK.
    ack_en = 3'b111; r0 = rsps;
    str_byte = 1; str_len = 1000; str_en = 1'b1;
    send(7'h74, 8'h01, 8'h0B);
    wait_rsp(r0, 20000);
    lat = rsp_cyc - acc_cyc;
    chk("str_latency", (lat >= 15490 && lat <= 15510), 1);
    chk("str_timeout", rsp_timeout, 0);
    chk("str_nack", rsp_nack, 0);
    r0 = rsps;
    str_byte = 0; str_len = 70000; str_en = 1'b1;
    send(7'h74, 8'h01, 8'h0B);
    wait_rsp(r0, 80000);
    chk("tmo_flag", rsp_timeout, 1);
    k = 0;
    while (scl_pull && k < 10000) begin @(negedge CLK); k++; end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
